// File: rtl/oserdes_feeder_pkg.sv
// Shared types and helpers for the O_SERDES word feeder.
// Link bring-up states, underrun counter width and the default training word.
package oserdes_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        RUN   = 2'd2
    } feeder_state_t;

    localparam int UNDERRUN_CNT_W = 8;

    // Alternating 1010... word with bit 0 = 0; wide enough for any legal WIDTH.
    function automatic logic [15:0] default_train_pattern(input int width);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < width) p[i] = (i % 2) == 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/oserdes_feeder_fifo.sv
// Small synchronous FIFO with combinational head and a one-cycle flush.
// Pointers wrap naturally; DEPTH must be a power of two.
module oserdes_feeder_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/oserdes_word_feeder.sv
// Feeds parallel words to an O_SERDES: IDLE -> fixed training burst -> payload,
// with idle-pattern insertion and a saturating count on FIFO underrun.
module oserdes_word_feeder
    import oserdes_feeder_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               FIFO_DEPTH    = 4,
    parameter int               TRAIN_WORDS   = 16,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(default_train_pattern(WIDTH)),
    parameter logic [WIDTH-1:0] IDLE_PATTERN  = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      pll_lock,
    input  logic [WIDTH-1:0]          s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [WIDTH-1:0]          word_out,
    output logic                      load_word,
    output logic                      oe,
    output logic                      train_done,
    output logic                      underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRAIN = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam int             TCW        = (TRAIN_WORDS > 2) ? $clog2(TRAIN_WORDS) : 1;
    localparam logic [TCW-1:0] TRAIN_LAST = TCW'((TRAIN_WORDS > 0) ? TRAIN_WORDS - 1 : 0);
    localparam logic [UNDERRUN_CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]               state_q;
    feeder_state_t            state_dbg;
    logic [TCW-1:0]           train_cnt;
    logic                     link_ok;
    logic                     abort;
    logic                     run_rule;
    logic                     from_idle;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [WIDTH-1:0]         head;
    logic [UNDERRUN_CNT_W-1:0] cnt_base;
    logic [UNDERRUN_CNT_W-1:0] cnt_next;

    // Named view of the state register for probes and checkers.
    assign state_dbg = feeder_state_t'(state_q);

    assign link_ok   = enable && pll_lock;
    assign s_ready   = reset && link_ok && !fifo_full;
    assign push      = s_valid && s_ready;
    assign abort     = (state_q != ST_IDLE) && !link_ok;
    assign from_idle = (state_q == ST_IDLE);

    // Edges on which the payload rule applies, including the two entries into RUN.
    assign run_rule = link_ok && ((state_q == ST_RUN)
                               || (state_q == ST_TRAIN && train_cnt == '0)
                               || (from_idle && TRAIN_WORDS == 0));
    assign pop      = run_rule && !fifo_empty;

    assign cnt_base = from_idle ? '0 : underrun_count;
    assign cnt_next = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;

    oserdes_feeder_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (abort),
        .push  (push),
        .pop   (pop),
        .wdata (s_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            train_cnt      <= '0;
            word_out       <= '0;
            load_word      <= 1'b0;
            oe             <= 1'b0;
            train_done     <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else if (abort) begin
            // Underrun status survives the abort until the next bring-up.
            state_q    <= ST_IDLE;
            word_out   <= '0;
            load_word  <= 1'b0;
            oe         <= 1'b0;
            train_done <= 1'b0;
        end else if (run_rule) begin
            state_q    <= ST_RUN;
            load_word  <= 1'b1;
            oe         <= 1'b1;
            train_done <= 1'b1;
            if (from_idle) begin
                underrun       <= 1'b0;
                underrun_count <= '0;
            end
            if (!fifo_empty) begin
                word_out <= head;
            end else begin
                word_out       <= IDLE_PATTERN;
                underrun       <= 1'b1;
                underrun_count <= cnt_next;
            end
        end else if (from_idle && link_ok) begin
            state_q        <= ST_TRAIN;
            train_cnt      <= TRAIN_LAST;
            word_out       <= TRAIN_PATTERN;
            load_word      <= 1'b1;
            oe             <= 1'b1;
            train_done     <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else if (state_q == ST_TRAIN) begin
            train_cnt <= train_cnt - 1'b1;
        end else begin
            state_q    <= ST_IDLE;
            word_out   <= '0;
            load_word  <= 1'b0;
            oe         <= 1'b0;
            train_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_oserdes_word_feeder.sv
// Scoreboard bench for oserdes_word_feeder: a queue-based reference model predicts
// every output cycle, a negedge monitor compares the DUT against those predictions.
module tb_oserdes_word_feeder;

    localparam int         W  = 4;
    localparam int         D  = 4;
    localparam int         TW = 4;
    localparam logic [3:0] TP = 4'b1010;
    localparam logic [3:0] IP = 4'b1100;

    logic         clock    = 1'b0;
    logic         reset    = 1'b0;
    logic         enable   = 1'b0;
    logic         pll_lock = 1'b0;
    logic [W-1:0] s_data   = '0;
    logic         s_valid  = 1'b0;
    logic         s_ready;
    logic [W-1:0] word_out;
    logic         load_word;
    logic         oe;
    logic         train_done;
    logic         underrun;
    logic [7:0]   underrun_count;

    always #5 clock = ~clock;

    oserdes_word_feeder #(
        .WIDTH         (W),
        .FIFO_DEPTH    (D),
        .TRAIN_WORDS   (TW),
        .TRAIN_PATTERN (TP),
        .IDLE_PATTERN  (IP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .pll_lock       (pll_lock),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .word_out       (word_out),
        .load_word      (load_word),
        .oe             (oe),
        .train_done     (train_done),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output per cycle: {word, load_word, oe, train_done, underrun, count}.
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    // Reference model: link phase (0 off, 1 training, 2 payload), words of training
    // already sent, payload queue and the observable output values.
    logic [W-1:0] m_fifo[$];
    int           m_mode    = 0;
    int           m_trained = 0;
    logic [W-1:0] m_word    = '0;
    logic         m_on      = 1'b0;
    logic         m_td      = 1'b0;
    logic         m_ur      = 1'b0;
    int           m_cnt     = 0;
    logic         m_acc;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_payload();
        m_mode = 2;
        m_on   = 1'b1;
        m_td   = 1'b1;
        if (m_fifo.size() > 0) begin
            m_word = m_fifo.pop_front();
        end else begin
            m_word = IP;
            m_ur   = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    always @(posedge clock) begin
        m_acc = s_valid && reset && enable && pll_lock && (m_fifo.size() < D);
        if (!reset) begin
            m_fifo.delete();
            m_mode = 0; m_word = '0; m_on = 1'b0; m_td = 1'b0; m_ur = 1'b0; m_cnt = 0;
        end else if (!(enable && pll_lock)) begin
            m_fifo.delete();
            m_mode = 0; m_word = '0; m_on = 1'b0; m_td = 1'b0;
        end else if (m_mode == 0) begin
            m_ur = 1'b0; m_cnt = 0;
            m_mode = 1; m_trained = 1; m_word = TP; m_on = 1'b1; m_td = 1'b0;
        end else if (m_mode == 1 && m_trained < TW) begin
            m_trained++;
        end else begin
            model_payload();
        end
        if (m_acc) m_fifo.push_back(s_data);
        exp_q.push_back({m_word, m_on, m_on, m_td, m_ur, 8'(m_cnt)});
    end

    always @(negedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("word_out",       32'(word_out),       32'(mon_e[15:12]));
            check("load_word",      32'(load_word),      32'(mon_e[11]));
            check("oe",             32'(oe),             32'(mon_e[10]));
            check("train_done",     32'(train_done),     32'(mon_e[9]));
            check("underrun",       32'(underrun),       32'(mon_e[8]));
            check("underrun_count", 32'(underrun_count), 32'(mon_e[7:0]));
        end
        check("s_ready", 32'(s_ready),
              32'(reset && enable && pll_lock && (m_fifo.size() < D)));
    end

    // All driver tasks start and end just after a falling edge.
    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic push_word(input logic [W-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (s_ready) begin
                @(negedge clock);
                return;
            end
            @(negedge clock);
        end
        check("push_timeout", 32'd1, 32'd0);
        s_valid = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        idle(3);
        reset = 1'b1;
        idle(2);

        // Bring-up with no payload: training burst then idle fill until saturation.
        enable = 1'b1; pll_lock = 1'b1;
        idle(4 + 270);
        enable = 1'b0;
        idle(2);

        // Prefill during training, then a continuous stream through RUN.
        enable = 1'b1;
        for (int v = 1; v <= 15; v++) push_word(4'(v));
        idle(6);

        // Underrun gap between two payload words.
        push_word(4'h7);
        idle(3);
        push_word(4'h8);
        idle(5);

        // Lock loss mid-training with words buffered.
        enable = 1'b0;
        idle(2);
        enable = 1'b1;
        push_word(4'h9);
        push_word(4'hA);
        pll_lock = 1'b0;
        idle(3);
        pll_lock = 1'b1;
        idle(10);

        // Reset while RUN holds buffered words.
        enable = 1'b0;
        idle(2);
        enable = 1'b1;
        for (int v = 1; v <= 4; v++) push_word(4'(v));
        idle(1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(10);

        // Random traffic with occasional link drops and resets.
        for (int c = 0; c < 3000; c++) begin
            s_valid  = ($urandom_range(0, 99) < 60);
            s_data   = 4'($urandom_range(0, 15));
            enable   = ($urandom_range(0, 99) != 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            pll_lock = ($urandom_range(0, 199) != 0);
            reset    = ($urandom_range(0, 499) != 0);
            @(negedge clock);
        end
        reset = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
